// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, pad marker word and the
// round-constant table consumed by the compression core.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_EMIT,
        ST_DONE
    } pad_state_e;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_padder.sv
// Message padder: packs a stream of 32-bit words into padded 512-bit
// blocks for the SHA-256 compression core.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      blk [16],
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             blk_last,
    output logic             done
);

    pad_state_e       state;
    logic [LEN_W-1:0] n;
    logic [LEN_W-1:0] cnt;
    logic [3:0]       widx;
    logic             marked;
    logic             lenblk;
    logic [63:0]      bitlen;
    logic [31:0]      pad_word;

    assign in_ready = (state == ST_LOAD);
    assign bitlen   = {{(64-LEN_W){1'b0}}, n} << 5;

    // marked: 0x80000000 already written; lenblk: this block carries the length
    always_comb begin
        pad_word = '0;
        if (!marked)
            pad_word = PAD_WORD;
        else if (lenblk && widx == 4'd14)
            pad_word = bitlen[63:32];
        else if (lenblk && widx == 4'd15)
            pad_word = bitlen[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            n         <= '0;
            cnt       <= '0;
            widx      <= '0;
            marked    <= 1'b0;
            lenblk    <= 1'b0;
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < 16; i++)
                blk[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n      <= msg_len;
                        cnt    <= '0;
                        widx   <= '0;
                        marked <= 1'b0;
                        lenblk <= 1'b0;
                        state  <= (msg_len == '0) ? ST_PAD : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        blk[widx] <= in_data;
                        widx      <= widx + 4'd1;
                        cnt       <= cnt + LEN_W'(1);
                        if (widx == 4'd15) begin
                            state     <= ST_EMIT;
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                        end else if (cnt + LEN_W'(1) == n) begin
                            state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    blk[widx] <= pad_word;
                    widx      <= widx + 4'd1;
                    if (!marked) begin
                        marked <= 1'b1;
                        if (widx <= 4'd13)
                            lenblk <= 1'b1;
                    end
                    if (widx == 4'd15) begin
                        state     <= ST_EMIT;
                        blk_valid <= 1'b1;
                        blk_last  <= lenblk;
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        widx      <= '0;
                        if (blk_last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else if (cnt != n) begin
                            state <= ST_LOAD;
                        end else begin
                            // marker spilled into the previous block
                            state <= ST_PAD;
                            if (marked)
                                lenblk <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
